// File: rtl/ps2_command_sender.sv
// PS/2 host-to-device command transmitter.
// Pulls the clock low to inhibit the keyboard, then presents a start bit and
// shifts one command byte, odd parity and a stop bit out on the device's
// falling clock edges, checks for the device ACK and returns to idle. Both
// open-drain lines are only ever driven low or released.

module ps2_command_sender #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    // One shared cycle counter serves the inhibit, start and transfer timers,
    // so it is sized for the largest of the three.
    localparam int MAX_A     = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int MAX_COUNT = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_BIT_AT = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_PARITY,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_drive_q, clk_drive_d;
    logic             dat_drive_q, dat_drive_d;
    logic             busy_q, busy_d;
    logic             sent_q, sent_d;
    logic             err_q, err_d;
    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;
    logic             clk_prev_q, clk_prev_d;
    logic             fall_edge;
    logic             in_xfer;

    // A drive flag of 1 pulls the line low; otherwise the line floats high.
    assign PS2_CLK = clk_drive_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_drive_q ? 1'b0 : 1'bz;

    assign busy                          = busy_q;
    assign command_was_sent              = sent_q;
    assign error_communication_timed_out = err_q;

    // Next-state logic: synchronise the lines, sequence the frame on device
    // falling edges and enforce the start and transfer timeouts.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        clk_drive_d = clk_drive_q;
        dat_drive_d = dat_drive_q;
        clk_sync_d  = {clk_sync_q[0], PS2_CLK};
        dat_sync_d  = {dat_sync_q[0], PS2_DAT};
        clk_prev_d  = clk_sync_q[1];
        fall_edge   = clk_prev_q & ~clk_sync_q[1];
        in_xfer     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send_command) begin
                    cmd_d       = the_command;
                    parity_d    = ~^the_command;
                    bit_cnt_d   = 4'd0;
                    cnt_d       = '0;
                    clk_drive_d = 1'b1;
                    state_d     = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == START_BIT_AT) begin
                    dat_drive_d = 1'b1;
                end
                if (cnt_q == INHIBIT_LAST) begin
                    clk_drive_d = 1'b0;
                    dat_drive_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall_edge) begin
                    dat_drive_d = ~cmd_q[0];
                    bit_cnt_d   = 4'd1;
                    cnt_d       = '0;
                    state_d     = S_DATA;
                end else if (cnt_q == START_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_DATA: begin
                in_xfer = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (fall_edge) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        dat_drive_d = ~parity_q;
                        state_d     = S_PARITY;
                    end else begin
                        dat_drive_d = ~cmd_q[bit_cnt_q[2:0]];
                    end
                end
            end
            S_PARITY: begin
                in_xfer = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (fall_edge) begin
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    dat_drive_d = 1'b0;
                    state_d     = S_ACK;
                end
            end
            S_ACK: begin
                in_xfer = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (fall_edge) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    state_d   = dat_sync_q[1] ? S_ERROR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                in_xfer = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (clk_sync_q[1] && dat_sync_q[1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (in_xfer && (cnt_q == XFER_LAST) && (state_d != S_DONE)) begin
            state_d = S_ERROR;
        end

        if ((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR)) begin
            clk_drive_d = 1'b0;
            dat_drive_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        sent_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    // State, datapath and registered outputs; reset releases both lines.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'd0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= 4'd0;
            cnt_q       <= '0;
            clk_drive_q <= 1'b0;
            dat_drive_q <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            clk_drive_q <= clk_drive_d;
            dat_drive_q <= dat_drive_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            err_q       <= err_d;
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

endmodule
